// File: rtl/control_unit_pkg.sv
// control_unit shared definitions: opcode map, flag bit positions,
// sequencer state encodings and the opcode classifier.
package control_unit_pkg;

   // ALU/LOAD with data-memory operand: 0x10..0x17 ALU ops, 0x18 LOAD
   localparam logic [7:0] OP_ADD_X   = 8'h10;
   localparam logic [7:0] OP_LOAD_X  = 8'h18;
   // ALU/LOAD with immediate operand: 0x20..0x27 ALU ops, 0x28 LOAD
   localparam logic [7:0] OP_ADD_I   = 8'h20;
   localparam logic [7:0] OP_SUB_I   = 8'h21;
   localparam logic [7:0] OP_LOAD_I  = 8'h28;
   localparam logic [7:0] OP_STORE_X = 8'h30;
   localparam logic [7:0] OP_JMP     = 8'h40;
   localparam logic [7:0] OP_JZ      = 8'h41;
   localparam logic [7:0] OP_JC      = 8'h42;
   localparam logic [7:0] OP_JN      = 8'h43;
   localparam logic [7:0] OP_JV      = 8'h44;
   localparam logic [7:0] OP_HALT    = 8'hFF;
   localparam logic [7:0] OP_NOP     = 8'h00;

   localparam int F_CARRY = 0;
   localparam int F_OV    = 1;
   localparam int F_ZERO  = 2;
   localparam int F_NEG   = 3;

   localparam logic [2:0] CU_S_FETCH0 = 3'd0;
   localparam logic [2:0] CU_S_FETCH1 = 3'd1;
   localparam logic [2:0] CU_S_FETCH2 = 3'd2;
   localparam logic [2:0] CU_S_DECODE = 3'd3;
   localparam logic [2:0] CU_S_MEM    = 3'd4;
   localparam logic [2:0] CU_S_EXEC   = 3'd5;
   localparam logic [2:0] CU_S_HALT   = 3'd6;

   typedef enum logic [2:0] {
      OPC_NOP,
      OPC_MEM,
      OPC_IMM,
      OPC_STORE,
      OPC_JUMP,
      OPC_HALT
   } opclass_e;

   function automatic opclass_e op_class(input logic [7:0] op);
      opclass_e c;
      c = OPC_NOP;
      if (op >= OP_ADD_X && op <= OP_LOAD_X)
         c = OPC_MEM;
      else if (op >= OP_ADD_I && op <= OP_LOAD_I)
         c = OPC_IMM;
      else if (op == OP_STORE_X)
         c = OPC_STORE;
      else if (op >= OP_JMP && op <= OP_JV)
         c = OPC_JUMP;
      else if (op == OP_HALT)
         c = OPC_HALT;
      return c;
   endfunction

endpackage

// File: rtl/control_unit_branch_eval.sv
// control_unit branch condition: decides whether a jump opcode
// redirects the PC, given the ALU flags from the last exec.
module control_unit_branch_eval
   import control_unit_pkg::*;
(
   input  logic [7:0] i_ir,
   input  logic [3:0] i_flags,
   output logic       o_take_branch
);

   // Non-jump opcodes never take a branch
   always_comb begin
      o_take_branch = 1'b0;
      unique case (i_ir)
         OP_JMP:  o_take_branch = 1'b1;
         OP_JZ:   o_take_branch = i_flags[F_ZERO];
         OP_JC:   o_take_branch = i_flags[F_CARRY];
         OP_JN:   o_take_branch = i_flags[F_NEG];
         OP_JV:   o_take_branch = i_flags[F_OV];
         default: o_take_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: two-byte instruction sequencer driving the ALU,
// data-memory stores and conditional jumps on ALU flags.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] pm_addr,
   input  logic [WIDTH-1:0] pm_data,
   output logic [WIDTH-1:0] dm_addr,
   output logic [WIDTH-1:0] dm_wdata,
   output logic             dm_we,
   input  logic [WIDTH-1:0] dm_rdata,
   output logic             exec,
   output logic [WIDTH-1:0] ir,
   output logic [WIDTH-1:0] ibr,
   output logic [WIDTH-1:0] mbr,
   input  logic [WIDTH-1:0] ar,
   input  logic [3:0]       flags,
   output logic             halted
);

   logic [2:0]       r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_ir;
   logic [WIDTH-1:0] r_ibr;
   logic [WIDTH-1:0] r_mbr;
   logic [WIDTH-1:0] r_pm_addr;
   logic [WIDTH-1:0] r_dm_addr;
   logic [WIDTH-1:0] r_dm_wdata;
   logic             r_dm_we;
   logic             w_take;
   opclass_e         w_class;

   assign w_class = op_class(r_ir[7:0]);

   control_unit_branch_eval u_branch (
      .i_ir          (r_ir[7:0]),
      .i_flags       (flags),
      .o_take_branch (w_take)
   );

   // Sequencer: fetch opcode/operand, decode, fetch memory operand, execute
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= CU_S_FETCH0;
         r_pc       <= '0;
         r_ir       <= '0;
         r_ibr      <= '0;
         r_mbr      <= '0;
         r_pm_addr  <= '0;
         r_dm_addr  <= '0;
         r_dm_wdata <= '0;
         r_dm_we    <= 1'b0;
      end else begin
         r_dm_we <= 1'b0;
         case (r_state)
            CU_S_FETCH0: begin
               r_pm_addr <= r_pc;
               r_state   <= CU_S_FETCH1;
            end
            CU_S_FETCH1: begin
               r_ir      <= pm_data;
               r_pm_addr <= r_pc + WIDTH'(1);
               r_state   <= CU_S_FETCH2;
            end
            CU_S_FETCH2: begin
               r_ibr   <= pm_data;
               r_pc    <= r_pc + WIDTH'(2);
               r_state <= CU_S_DECODE;
            end
            CU_S_DECODE: begin
               case (w_class)
                  OPC_MEM: begin
                     r_dm_addr <= r_ibr;
                     r_state   <= CU_S_MEM;
                  end
                  OPC_IMM: r_state <= CU_S_EXEC;
                  OPC_STORE: begin
                     r_dm_addr  <= r_ibr;
                     r_dm_wdata <= ar;
                     r_dm_we    <= 1'b1;
                     r_state    <= CU_S_FETCH0;
                  end
                  OPC_JUMP: begin
                     if (w_take)
                        r_pc <= r_ibr;
                     r_state <= CU_S_FETCH0;
                  end
                  OPC_HALT: r_state <= CU_S_HALT;
                  default:  r_state <= CU_S_FETCH0;
               endcase
            end
            CU_S_MEM: begin
               r_mbr   <= dm_rdata;
               r_state <= CU_S_EXEC;
            end
            CU_S_EXEC: r_state <= CU_S_FETCH0;
            CU_S_HALT: r_state <= CU_S_HALT;
            default:   r_state <= CU_S_FETCH0;
         endcase
      end
   end

   assign pm_addr  = r_pm_addr;
   assign dm_addr  = r_dm_addr;
   assign dm_wdata = r_dm_wdata;
   assign dm_we    = r_dm_we;
   assign ir       = r_ir;
   assign ibr      = r_ibr;
   assign mbr      = r_mbr;
   assign exec     = (r_state == CU_S_EXEC);
   assign halted   = (r_state == CU_S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: ISA-level reference interpreter predicts timed
// events into a scoreboard; a negedge monitor pops and compares them.
module tb_control_unit;
   import control_unit_pkg::*;

   localparam int K_FETCH = 0;
   localparam int K_EXEC  = 1;
   localparam int K_STORE = 2;
   localparam int K_HALT  = 3;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] c;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pm_addr, pm_data, dm_addr, dm_wdata, dm_rdata;
   logic [7:0] ir, ibr, mbr, ar;
   logic       dm_we, exec, halted;
   logic [3:0] flags;

   logic [7:0] pm [256];
   logic [7:0] dm [256];

   int   total = 0;
   int   bad = 0;
   ev_t  sb[$];
   int   cyc = 0;
   bit   in_rst = 0;
   bit   exp_halted;
   logic [7:0] exp_halt_pm;
   logic [7:0] exp_ar;

   always #5 clk = ~clk;

   control_unit #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pm_addr  (pm_addr),
      .pm_data  (pm_data),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_we    (dm_we),
      .dm_rdata (dm_rdata),
      .exec     (exec),
      .ir       (ir),
      .ibr      (ibr),
      .mbr      (mbr),
      .ar       (ar),
      .flags    (flags),
      .halted   (halted)
   );

   assign pm_data  = pm[pm_addr];
   assign dm_rdata = dm[dm_addr];

   // Returns {flags[3:0], result[7:0]}; flags = {NEG, ZERO, OV, CARRY}
   function automatic logic [11:0] alu_f(input logic [7:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic       c, v;
      c = 1'b0;
      v = 1'b0;
      r = a;
      case (op[3:0])
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         4'd1: begin
            s = {1'b0, a} - {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~(a & b);
         4'd6: r = ~(a | b);
         4'd7: r = ~(a ^ b);
         4'd8: r = b;
         default: r = a;
      endcase
      return {r[7], (r == 8'h00), v, c, r};
   endfunction

   // Environment: ALU updating on exec, data memory written on dm_we
   always @(posedge clk) begin
      if (!rst_n) begin
         ar    <= 8'h00;
         flags <= 4'h0;
      end else if (exec) begin
         {flags, ar} <= alu_f(ir, ar, (ir < OP_ADD_I) ? mbr : ibr);
      end
      if (dm_we)
         dm[dm_addr] <= dm_wdata;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic void push(input int k, input int c,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] d, input int lim);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.a    = a;
      e.b    = b;
      e.c    = d;
      if (lim == 0 || c < lim)
         sb.push_back(e);
   endfunction

   // Instruction-level interpreter: cycle stamps from per-class latency
   task automatic model(input int lim);
      logic [7:0]  m [256];
      logic [7:0]  pc, op, opd, a, mb;
      logic [3:0]  fl;
      logic [11:0] res;
      int          s;
      bit          take;
      for (int i = 0; i < 256; i++) m[i] = dm[i];
      pc = 8'h00; a = 8'h00; fl = 4'h0; mb = 8'h00; s = 1;
      exp_halted = 0;
      for (int n = 0; n < 40; n++) begin
         op  = pm[pc];
         opd = pm[pc + 8'd1];
         push(K_FETCH, s + 1, pc, 8'h00, 8'h00, lim);
         push(K_FETCH, s + 2, pc + 8'd1, 8'h00, 8'h00, lim);
         if (op >= OP_ADD_X && op <= OP_LOAD_X) begin
            mb = m[opd];
            push(K_EXEC, s + 5, op, opd, mb, lim);
            res = alu_f(op, a, mb);
            {fl, a} = res;
            s += 6;
            pc += 8'd2;
         end else if (op >= OP_ADD_I && op <= OP_LOAD_I) begin
            push(K_EXEC, s + 4, op, opd, mb, lim);
            res = alu_f(op, a, opd);
            {fl, a} = res;
            s += 5;
            pc += 8'd2;
         end else if (op == OP_STORE_X) begin
            push(K_STORE, s + 4, opd, a, 8'h00, lim);
            m[opd] = a;
            s += 4;
            pc += 8'd2;
         end else if (op >= OP_JMP && op <= OP_JV) begin
            take = (op == OP_JMP) || (op == OP_JZ && fl[F_ZERO]) ||
                   (op == OP_JC && fl[F_CARRY]) ||
                   (op == OP_JN && fl[F_NEG]) || (op == OP_JV && fl[F_OV]);
            pc = take ? opd : pc + 8'd2;
            s += 4;
         end else if (op == OP_HALT) begin
            push(K_HALT, s + 4, pc + 8'd1, 8'h00, 8'h00, lim);
            exp_halted  = (lim == 0);
            exp_halt_pm = pc + 8'd1;
            break;
         end else begin
            s += 4;
            pc += 8'd2;
         end
      end
      exp_ar = a;
   endtask

   // Monitor: pops due events and flags strobes nobody predicted
   always @(negedge clk) begin
      bit  mx, mw;
      ev_t e;
      mx = 0;
      mw = 0;
      if (!rst_n) begin
         if (in_rst)
            chk("reset_quiet", {29'd0, exec, dm_we, halted}, 32'd0);
         in_rst = 1;
         cyc = 0;
      end else begin
         in_rst = 0;
         cyc++;
         while (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            case (e.kind)
               K_FETCH: chk("fetch_addr", {halted, pm_addr}, {1'b0, e.a});
               K_EXEC: begin
                  mx = 1;
                  chk("exec", {exec, dm_we, ir, ibr, mbr},
                      {2'b10, e.a, e.b, e.c});
               end
               K_STORE: begin
                  mw = 1;
                  chk("store", {dm_we, exec, dm_addr, dm_wdata},
                      {2'b10, e.a, e.b});
               end
               default: chk("halt", {halted, pm_addr}, {1'b1, e.a});
            endcase
         end
         if (exec && !mx)
            chk("unexpected_exec", {31'd0, exec}, 32'd0);
         if (dm_we && !mw)
            chk("unexpected_dm_we", {31'd0, dm_we}, 32'd0);
      end
   end

   task automatic reset_dut();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state_a", {pm_addr, dm_addr, dm_wdata, ir}, 32'd0);
      chk("reset_state_b", {13'd0, ibr, mbr, exec, dm_we, halted}, 32'd0);
   endtask

   task automatic run(input int abort_at);
      int t;
      reset_dut();
      sb.delete();
      model(abort_at);
      rst_n = 1'b1;
      if (abort_at != 0) begin
         repeat (abort_at - 1) @(posedge clk);
         #1 rst_n = 1'b0;
         chk("abort_pending", sb.size(), 32'd0);
         sb.delete();
         return;
      end
      t = 0;
      while (sb.size() != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      chk("scoreboard_drain", sb.size(), 32'd0);
      sb.delete();
      if (exp_halted) begin
         repeat (20) @(posedge clk);
         #1;
         chk("halt_hold", {halted, pm_addr}, {1'b1, exp_halt_pm});
         chk("final_ar", ar, exp_ar);
      end
   endtask

   task automatic clr();
      for (int i = 0; i < 256; i++) begin
         pm[i] = OP_HALT;
         dm[i] = 8'(i * 7 + 3);
      end
   endtask

   initial begin
      logic [7:0] op, opd;
      int         k;
      // LOAD_I 5; ADD_I 3
      clr();
      pm[0] = OP_LOAD_I; pm[1] = 8'h05;
      pm[2] = OP_ADD_I;  pm[3] = 8'h03;
      run(0);
      chk("add_result", ar, 32'h08);
      // LOAD_X from 0x10
      clr();
      dm[8'h10] = 8'h7F;
      pm[0] = OP_LOAD_X; pm[1] = 8'h10;
      run(0);
      // LOAD_I 8; STORE_X 0x20
      clr();
      pm[0] = OP_LOAD_I;  pm[1] = 8'h08;
      pm[2] = OP_STORE_X; pm[3] = 8'h20;
      run(0);
      chk("dm_written", dm[8'h20], 32'h08);
      // JZ taken then not taken
      clr();
      pm[0] = OP_LOAD_I; pm[1] = 8'h01;
      pm[2] = OP_SUB_I;  pm[3] = 8'h01;
      pm[4] = OP_JZ;     pm[5] = 8'h40;
      run(0);
      pm[1] = 8'h02;
      run(0);
      // JMP 0xFE with NOPs at the top: wraps to 0x00
      clr();
      pm[0] = OP_JMP; pm[1] = 8'hFE;
      pm[8'hFE] = OP_NOP; pm[8'hFF] = OP_NOP;
      run(0);
      // HALT at address 0
      clr();
      run(0);
      // Reset during S_MEM, then a clean rerun
      clr();
      pm[0] = OP_LOAD_X; pm[1] = 8'h10;
      run(5);
      run(0);
      // Random programs
      for (int p = 0; p < 25; p++) begin
         clr();
         for (int i = 0; i < 16; i++) dm[8'h80 + i] = 8'($urandom);
         for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 5);
            case (k)
               0: begin
                  op  = 8'(OP_ADD_X + $urandom_range(0, 8));
                  opd = 8'(8'h80 + $urandom_range(0, 15));
               end
               1, 5: begin
                  op  = 8'(OP_ADD_I + $urandom_range(0, 8));
                  opd = 8'($urandom);
               end
               2: begin
                  op  = OP_STORE_X;
                  opd = 8'(8'h80 + $urandom_range(0, 15));
               end
               3: begin
                  op  = 8'(OP_JMP + $urandom_range(0, 4));
                  opd = 8'(2 * $urandom_range(0, 12));
               end
               default: begin
                  op  = ($urandom_range(0, 1) == 0) ? OP_NOP : 8'h55;
                  opd = 8'($urandom);
               end
            endcase
            pm[2 * i]     = op;
            pm[2 * i + 1] = opd;
         end
         run(0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
